mem_bus_arbiter: RTL and testbench
==================================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: number of BUSY cycles tolerated without mem_cplt before abort (8-bit range, 1..255).
REQ-002 clk  in  1  single core clock; all state updates on the rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 int_req, int_addr, int_rw, int_size, int_wdata  in  1/32/2/2/32  interrupt-context requester; rw 2=read, 3=write; size 0..3 means 1..4 bytes.
REQ-005 int_rdata, int_cplt  out  32/1  interrupt read data and one-cycle completion pulse.
REQ-006 dat_req, dat_addr, dat_rw, dat_size, dat_wdata  in  1/32/2/2/32  execute-stage data requester; encoding as REQ-004.
REQ-007 dat_rdata, dat_cplt  out  32/1  data-path read data and completion pulse.
REQ-008 fet_req, fet_addr  in  1/32  instruction fetch requester; always a 4-byte read.
REQ-009 fet_rdata, fet_cplt  out  32/1  fetched instruction word and completion pulse.
REQ-010 mem_addr, mem_wdata, mem_rw, mem_size  out  32/32/2/2  shared external memory bus; mem_rw 0 means idle.
REQ-011 mem_rdata, mem_cplt  in  32/1  external read data and completion.
REQ-012 busy  out  1  high whenever state is not IDLE.
REQ-013 grant  out  2  current owner: 0 none, 1 int, 2 dat, 3 fet.
REQ-014 timeout_err  out  1  sticky abort flag.

Function
REQ-015 FSM states: IDLE, BUSY, RESP; all outputs registered.
REQ-016 In IDLE, priority: int_req highest; between dat_req and fet_req, round-robin using a last-winner bit.
REQ-017 The last-winner bit updates only on a dat or fet grant; int grants leave it unchanged.
REQ-018 On the grant edge, latch the winner's addr/rw/size/wdata, set grant, and enter BUSY; a fet grant latches rw=2, size=3.
REQ-019 A granted request with rw 0 or 1 enters RESP directly with rdata=0; no bus access occurs.
REQ-020 In BUSY, drive the latched values on mem_*; mem_wdata equals the latched wdata when rw=3 and 0 otherwise.
REQ-021 On the edge where mem_cplt=1 in BUSY: capture mem_rdata into the owner's rdata register (reads only), set mem_rw=0, and enter RESP.
REQ-022 In RESP, the owner's cplt is high for exactly one cycle; the next state is IDLE and grant returns to 0.
REQ-023 Minimum latency, request sampled to cplt high: 3 cycles when mem_cplt is asserted in the first BUSY cycle.
REQ-024 A requester holds req and operands stable until its cplt, then deasserts req on the edge at which cplt is sampled.
REQ-025 Request changes during BUSY/RESP are ignored; a new arbitration occurs only in IDLE.
REQ-026 mem_cplt outside BUSY is ignored.
REQ-027 rdata registers hold their value until the owner's next completed read.
REQ-028 Simultaneous int/dat/fet requests are served in the order int, then dat or fet per round-robin, then the remaining one, with one IDLE cycle between transactions.

Reset
REQ-029 rst forces IDLE; grant=0; mem_rw=0; mem_addr, mem_wdata, mem_size, and all rdata = 0; all cplt=0; busy=0; timeout_err=0; last-winner = fet (so dat wins the first tie).
REQ-030 rst during BUSY or RESP abandons the transaction; no cplt is emitted for it.

Configuration
REQ-031 Macro MEM_BUS_ARBITER_TIMEOUT_EN defined: an 8-bit counter clears on entering BUSY and increments each BUSY cycle; reaching TIMEOUT_CYCLES without mem_cplt forces RESP with owner rdata=0 and sets timeout_err until rst.
REQ-032 Macro undefined: no counter is built, BUSY waits indefinitely, and timeout_err is tied 0.

Verification
REQ-033 After reset, fet_req=1 at addr 0x100 with mem_cplt one cycle after mem_rw=2 and mem_rdata=0x12345678 -> mem_size=3; fet_rdata=0x12345678; fet_cplt pulses once; grant sequence 3 then 0.
REQ-034 dat_req (rw=3, addr 0x2000, wdata 0xA5A5A5A5, size 1) and fet_req asserted on the same cycle -> dat served first with mem_wdata=0xA5A5A5A5, then fet; next tie -> fet first.
REQ-035 int_req, dat_req, and fet_req all asserted -> grant order 1, then 2, then 3; each cplt is a one-cycle pulse; busy drops between transactions.
REQ-036 dat_req with rw=1 -> no mem_rw activity; dat_cplt 2 cycles after sampling; dat_rdata=0.
REQ-037 rst asserted during BUSY with mem_cplt arriving next cycle -> IDLE, no cplt, mem_rw=0, and the late mem_cplt is ignored.
REQ-038 With MEM_BUS_ARBITER_TIMEOUT_EN and TIMEOUT_CYCLES=4, a read where mem_cplt is never asserted -> after 4 BUSY cycles, owner cplt pulses with rdata=0 and timeout_err stays 1 until rst.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Three-requester arbiter (interrupt > data/fetch round-robin) for one shared memory bus.
// Optional BUSY watchdog is built when MEM_BUS_ARBITER_TIMEOUT_EN is defined.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        int_req,
  input  logic [31:0] int_addr,
  input  logic [1:0]  int_rw,
  input  logic [1:0]  int_size,
  input  logic [31:0] int_wdata,
  output logic [31:0] int_rdata,
  output logic        int_cplt,

  input  logic        dat_req,
  input  logic [31:0] dat_addr,
  input  logic [1:0]  dat_rw,
  input  logic [1:0]  dat_size,
  input  logic [31:0] dat_wdata,
  output logic [31:0] dat_rdata,
  output logic        dat_cplt,

  input  logic        fet_req,
  input  logic [31:0] fet_addr,
  output logic [31:0] fet_rdata,
  output logic        fet_cplt,

  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_rw,
  output logic [1:0]  mem_size,
  input  logic [31:0] mem_rdata,
  input  logic        mem_cplt,

  output logic        busy,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INT  = 2'd1,
    OWN_DAT  = 2'd2,
    OWN_FET  = 2'd3
  } owner_e;

  localparam logic [1:0] RW_READ  = 2'd2;
  localparam logic [1:0] RW_WRITE = 2'd3;

  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must lie in 1..255");
  end

  state_e      state_q, state_d;
  owner_e      grant_q, grant_d;
  logic        last_fet_q, last_fet_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]  mem_rw_q, mem_rw_d;
  logic [1:0]  mem_size_q, mem_size_d;
  logic [31:0] int_rdata_q, int_rdata_d;
  logic [31:0] dat_rdata_q, dat_rdata_d;
  logic [31:0] fet_rdata_q, fet_rdata_d;
  logic        int_cplt_q, int_cplt_d;
  logic        dat_cplt_q, dat_cplt_d;
  logic        fet_cplt_q, fet_cplt_d;
  logic        busy_q, busy_d;
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;
  logic        timeout_err_q, timeout_err_d;
`endif

  owner_e      win;
  owner_e      own;
  logic [31:0] sel_addr;
  logic [1:0]  sel_rw;
  logic [1:0]  sel_size;
  logic [31:0] sel_wdata;
  logic        finish;
  logic        load_rd;
  logic [31:0] rd_val;

  // NOTE: every combinational output gets a default before any branch so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_fet_d  = last_fet_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_rw_d    = mem_rw_q;
    mem_size_d  = mem_size_q;
    int_rdata_d = int_rdata_q;
    dat_rdata_d = dat_rdata_q;
    fet_rdata_d = fet_rdata_q;
    int_cplt_d  = 1'b0;
    dat_cplt_d  = 1'b0;
    fet_cplt_d  = 1'b0;
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
    tmo_cnt_d     = tmo_cnt_q;
    timeout_err_d = timeout_err_q;
`endif
    win       = OWN_NONE;
    own       = grant_q;
    sel_addr  = '0;
    sel_rw    = '0;
    sel_size  = '0;
    sel_wdata = '0;
    finish    = 1'b0;
    load_rd   = 1'b0;
    rd_val    = '0;

    // Interrupt always wins; a data/fetch tie goes to whichever did not win last.
    if (int_req)                 win = OWN_INT;
    else if (dat_req && fet_req) win = last_fet_q ? OWN_DAT : OWN_FET;
    else if (dat_req)            win = OWN_DAT;
    else if (fet_req)            win = OWN_FET;

    unique case (win)
      OWN_INT: begin
        sel_addr = int_addr;  sel_rw = int_rw;  sel_size = int_size;  sel_wdata = int_wdata;
      end
      OWN_DAT: begin
        sel_addr = dat_addr;  sel_rw = dat_rw;  sel_size = dat_size;  sel_wdata = dat_wdata;
      end
      OWN_FET: begin
        sel_addr = fet_addr;  sel_rw = RW_READ;  sel_size = 2'd3;  sel_wdata = '0;
      end
      default: ;
    endcase

    unique case (state_q)
      ST_IDLE: begin
        own = win;
        if (win != OWN_NONE) begin
          grant_d = win;
          if (win == OWN_DAT) last_fet_d = 1'b0;
          if (win == OWN_FET) last_fet_d = 1'b1;
          if (sel_rw == RW_READ || sel_rw == RW_WRITE) begin
            state_d     = ST_BUSY;
            mem_addr_d  = sel_addr;
            mem_rw_d    = sel_rw;
            mem_size_d  = sel_size;
            mem_wdata_d = (sel_rw == RW_WRITE) ? sel_wdata : '0;
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
            tmo_cnt_d   = '0;
`endif
          end else begin
            // Non-access opcodes complete without touching the bus.
            state_d = ST_RESP;
            finish  = 1'b1;
            load_rd = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        if (mem_cplt) begin
          state_d  = ST_RESP;
          mem_rw_d = '0;
          finish   = 1'b1;
          load_rd  = (mem_rw_q == RW_READ);
          rd_val   = mem_rdata;
        end
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
        else if (tmo_cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
          state_d       = ST_RESP;
          mem_rw_d      = '0;
          finish        = 1'b1;
          load_rd       = 1'b1;
          timeout_err_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
`endif
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        grant_d = OWN_NONE;
      end
      default: state_d = ST_IDLE;
    endcase

    // The completion pulse is raised on the edge entering RESP, so it is visible for the whole RESP cycle.
    if (finish) begin
      unique case (own)
        OWN_INT: int_cplt_d = 1'b1;
        OWN_DAT: dat_cplt_d = 1'b1;
        OWN_FET: fet_cplt_d = 1'b1;
        default: ;
      endcase
    end
    if (load_rd) begin
      unique case (own)
        OWN_INT: int_rdata_d = rd_val;
        OWN_DAT: dat_rdata_d = rd_val;
        OWN_FET: fet_rdata_d = rd_val;
        default: ;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= OWN_NONE;
      last_fet_q  <= 1'b1;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rw_q    <= '0;
      mem_size_q  <= '0;
      int_rdata_q <= '0;
      dat_rdata_q <= '0;
      fet_rdata_q <= '0;
      int_cplt_q  <= 1'b0;
      dat_cplt_q  <= 1'b0;
      fet_cplt_q  <= 1'b0;
      busy_q      <= 1'b0;
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_fet_q  <= last_fet_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_rw_q    <= mem_rw_d;
      mem_size_q  <= mem_size_d;
      int_rdata_q <= int_rdata_d;
      dat_rdata_q <= dat_rdata_d;
      fet_rdata_q <= fet_rdata_d;
      int_cplt_q  <= int_cplt_d;
      dat_cplt_q  <= dat_cplt_d;
      fet_cplt_q  <= fet_cplt_d;
      busy_q      <= busy_d;
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
      tmo_cnt_q     <= tmo_cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_rw    = mem_rw_q;
  assign mem_size  = mem_size_q;
  assign int_rdata = int_rdata_q;
  assign dat_rdata = dat_rdata_q;
  assign fet_rdata = fet_rdata_q;
  assign int_cplt  = int_cplt_q;
  assign dat_cplt  = dat_cplt_q;
  assign fet_cplt  = fet_cplt_q;
  assign busy      = busy_q;
  assign grant     = grant_q;
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: expected completions are queued at stimulus time
// and popped by a monitor when a cplt pulse appears.
module tb_mem_bus_arbiter;

  localparam logic [1:0] O_INT = 2'd1;
  localparam logic [1:0] O_DAT = 2'd2;
  localparam logic [1:0] O_FET = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        int_req, dat_req, fet_req;
  logic [31:0] int_addr, dat_addr, fet_addr;
  logic [1:0]  int_rw, int_size, dat_rw, dat_size;
  logic [31:0] int_wdata, dat_wdata;
  logic [31:0] int_rdata, dat_rdata, fet_rdata;
  logic        int_cplt, dat_cplt, fet_cplt;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_rw, mem_size;
  logic        mem_cplt;
  logic        busy, timeout_err;
  logic [1:0]  grant;

  typedef struct {
    logic [1:0]  owner;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] exp_rd [4];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [2:0]  cv, prev_cv = 3'b000;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .int_req(int_req), .int_addr(int_addr), .int_rw(int_rw), .int_size(int_size),
    .int_wdata(int_wdata), .int_rdata(int_rdata), .int_cplt(int_cplt),
    .dat_req(dat_req), .dat_addr(dat_addr), .dat_rw(dat_rw), .dat_size(dat_size),
    .dat_wdata(dat_wdata), .dat_rdata(dat_rdata), .dat_cplt(dat_cplt),
    .fet_req(fet_req), .fet_addr(fet_addr), .fet_rdata(fet_rdata), .fet_cplt(fet_cplt),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rw(mem_rw), .mem_size(mem_size),
    .mem_rdata(mem_rdata), .mem_cplt(mem_cplt),
    .busy(busy), .grant(grant), .timeout_err(timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic cplt_of(input logic [1:0] own);
    case (own)
      O_INT:   return int_cplt;
      O_DAT:   return dat_cplt;
      O_FET:   return fet_cplt;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] rdata_of(input logic [1:0] own);
    case (own)
      O_INT:   return int_rdata;
      O_DAT:   return dat_rdata;
      O_FET:   return fet_rdata;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [1:0] owner_of(input logic [2:0] v);
    case (v)
      3'b001:  return O_INT;
      3'b010:  return O_DAT;
      3'b100:  return O_FET;
      default: return 2'd0;
    endcase
  endfunction

  task automatic push_exp(input logic [1:0] own, input logic [31:0] val);
    exp_t e;
    e.owner = own;
    e.rdata = val;
    exp_rd[own] = val;
    exp_q.push_back(e);
  endtask

  task automatic set_int(input logic r, input logic [1:0] rw, input logic [31:0] a,
                         input logic [1:0] sz, input logic [31:0] wd);
    int_req = r; int_rw = rw; int_addr = a; int_size = sz; int_wdata = wd;
  endtask

  task automatic set_dat(input logic r, input logic [1:0] rw, input logic [31:0] a,
                         input logic [1:0] sz, input logic [31:0] wd);
    dat_req = r; dat_rw = rw; dat_addr = a; dat_size = sz; dat_wdata = wd;
  endtask

  task automatic set_fet(input logic r, input logic [31:0] a);
    fet_req = r; fet_addr = a;
  endtask

  task automatic drop_req(input logic [1:0] own);
    case (own)
      O_INT:   int_req = 1'b0;
      O_DAT:   dat_req = 1'b0;
      O_FET:   fet_req = 1'b0;
      default: ;
    endcase
  endtask

  task automatic reset_model();
    for (int i = 0; i < 4; i++) exp_rd[i] = 32'h0;
  endtask

  // Entered one step after the grant edge; answers after `delay` extra BUSY cycles and ends in IDLE.
  task automatic serve_busy(input string tag, input logic [1:0] own, input logic [1:0] rw,
                            input logic [31:0] addr, input logic [1:0] size,
                            input logic [31:0] wdata, input logic [31:0] rdata, input int delay);
    check({tag, "_grant"}, 32'(grant), 32'(own));
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_mem_rw"}, 32'(mem_rw), 32'(rw));
    check({tag, "_mem_addr"}, mem_addr, addr);
    check({tag, "_mem_size"}, 32'(mem_size), 32'(size));
    check({tag, "_mem_wdata"}, mem_wdata, (rw == 2'd3) ? wdata : 32'h0);
    check({tag, "_no_early_cplt"}, 32'(cplt_of(own)), 32'd0);
    for (int i = 0; i < delay; i++) begin
      tick();
      check({tag, "_wait_mem_rw"}, 32'(mem_rw), 32'(rw));
    end
    mem_cplt = 1'b1;
    mem_rdata = rdata;
    tick();
    mem_cplt = 1'b0;
    mem_rdata = 32'hDEAD_BEEF;
    check({tag, "_resp_mem_rw"}, 32'(mem_rw), 32'd0);
    check({tag, "_resp_cplt"}, 32'(cplt_of(own)), 32'd1);
    check({tag, "_resp_grant"}, 32'(grant), 32'(own));
    tick();
    drop_req(own);
    check({tag, "_idle_grant"}, 32'(grant), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_idle_cplt"}, 32'(cplt_of(own)), 32'd0);
  endtask

  // Every cplt pulse must be one-hot, one cycle wide, and match the next queued expectation.
  always @(negedge clk) begin
    cv = {fet_cplt, dat_cplt, int_cplt};
    if (cv != 3'b000) begin
      check("cplt_pulse_width", 32'(cv & prev_cv), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_cplt", 32'(cv), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("cplt_owner", 32'(owner_of(cv)), 32'(e.owner));
        check("cplt_rdata", rdata_of(owner_of(cv)), e.rdata);
      end
    end
    prev_cv = cv;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    set_int(1'b0, 2'd0, 32'h0, 2'd0, 32'h0);
    set_dat(1'b0, 2'd0, 32'h0, 2'd0, 32'h0);
    set_fet(1'b0, 32'h0);
    mem_cplt = 1'b0;
    mem_rdata = 32'h0;
    reset_model();
    repeat (2) tick();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_rw", 32'(mem_rw), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_size", 32'(mem_size), 32'd0);
    check("rst_rdata_or", int_rdata | dat_rdata | fet_rdata, 32'h0);
    check("rst_cplts", 32'({int_cplt, dat_cplt, fet_cplt}), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    rst = 1'b0;
    tick();

    // Single fetch, memory answers in the first BUSY cycle.
    set_fet(1'b1, 32'h100);
    push_exp(O_FET, 32'h1234_5678);
    tick();
    serve_busy("fet0", O_FET, 2'd2, 32'h100, 2'd3, 32'h0, 32'h1234_5678, 0);
    check("fet0_rdata_held", fet_rdata, 32'h1234_5678);

    // Three-way contention: int, then dat (fet won last), then fet.
    set_int(1'b1, 2'd2, 32'h10, 2'd2, 32'h0);
    set_dat(1'b1, 2'd2, 32'h20, 2'd0, 32'h0);
    set_fet(1'b1, 32'h400);
    push_exp(O_INT, 32'hCAFE_0001);
    push_exp(O_DAT, 32'h0000_00EE);
    push_exp(O_FET, 32'h0BAD_F00D);
    tick();
    serve_busy("tri_int", O_INT, 2'd2, 32'h10, 2'd2, 32'h0, 32'hCAFE_0001, 0);
    tick();
    serve_busy("tri_dat", O_DAT, 2'd2, 32'h20, 2'd0, 32'h0, 32'h0000_00EE, 2);
    tick();
    serve_busy("tri_fet", O_FET, 2'd2, 32'h400, 2'd3, 32'h0, 32'h0BAD_F00D, 0);

    // dat/fet tie: dat write first; dat re-requests at once, so the next tie goes to fet.
    set_dat(1'b1, 2'd3, 32'h2000, 2'd1, 32'hA5A5_A5A5);
    set_fet(1'b1, 32'h300);
    push_exp(O_DAT, exp_rd[O_DAT]);
    push_exp(O_FET, 32'h600D_0001);
    tick();
    serve_busy("rr_dat_wr", O_DAT, 2'd3, 32'h2000, 2'd1, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 0);
    check("rr_dat_rdata_kept", dat_rdata, 32'h0000_00EE);
    set_dat(1'b1, 2'd2, 32'h2004, 2'd3, 32'h0);
    push_exp(O_DAT, 32'h0000_D472);
    tick();
    serve_busy("rr_fet", O_FET, 2'd2, 32'h300, 2'd3, 32'h0, 32'h600D_0001, 1);
    tick();
    serve_busy("rr_dat_rd", O_DAT, 2'd2, 32'h2004, 2'd3, 32'h0, 32'h0000_D472, 0);

    // rw=1: straight to RESP, no bus activity, rdata cleared.
    set_dat(1'b1, 2'd1, 32'h3000, 2'd2, 32'h1234);
    push_exp(O_DAT, 32'h0);
    tick();
    check("nop_grant", 32'(grant), 32'(O_DAT));
    check("nop_mem_rw", 32'(mem_rw), 32'd0);
    check("nop_cplt", 32'(dat_cplt), 32'd1);
    check("nop_mem_addr_untouched", mem_addr, 32'h2004);
    tick();
    drop_req(O_DAT);
    check("nop_idle_busy", 32'(busy), 32'd0);
    check("nop_idle_grant", 32'(grant), 32'd0);

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
    // Memory never answers: abort after exactly 4 BUSY cycles, sticky error until reset.
    set_int(1'b1, 2'd2, 32'h40, 2'd3, 32'h0);
    push_exp(O_INT, 32'h0);
    tick();
    check("tmo_grant", 32'(grant), 32'(O_INT));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("tmo_still_busy", 32'(mem_rw), 32'd2);
      check("tmo_err_low", 32'(timeout_err), 32'd0);
    end
    tick();
    check("tmo_cplt", 32'(int_cplt), 32'd1);
    check("tmo_mem_rw", 32'(mem_rw), 32'd0);
    check("tmo_err_set", 32'(timeout_err), 32'd1);
    tick();
    drop_req(O_INT);
    check("tmo_idle_busy", 32'(busy), 32'd0);
    tick();
    check("tmo_err_sticky", 32'(timeout_err), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    reset_model();
    check("tmo_err_cleared", 32'(timeout_err), 32'd0);
`else
    // Without the watchdog BUSY waits as long as memory takes.
    set_int(1'b1, 2'd2, 32'h40, 2'd3, 32'h0);
    push_exp(O_INT, 32'h5A5A_5A5A);
    tick();
    serve_busy("slow_int", O_INT, 2'd2, 32'h40, 2'd3, 32'h0, 32'h5A5A_5A5A, 20);
    check("slow_timeout_err", 32'(timeout_err), 32'd0);
`endif

    // Reset in BUSY abandons the fetch; the late mem_cplt must be ignored.
    set_fet(1'b1, 32'h500);
    tick();
    check("abort_mem_rw", 32'(mem_rw), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    reset_model();
    set_fet(1'b0, 32'h0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_grant", 32'(grant), 32'd0);
    check("abort_mem_rw_idle", 32'(mem_rw), 32'd0);
    mem_cplt = 1'b1;
    mem_rdata = 32'h7777_7777;
    tick();
    mem_cplt = 1'b0;
    check("late_cplt_busy", 32'(busy), 32'd0);
    check("late_cplt_rdata", fet_rdata, 32'h0);
    check("late_cplt_mem_rw", 32'(mem_rw), 32'd0);

    // After reset dat wins the first tie (rw=0 completes without the bus).
    set_dat(1'b1, 2'd0, 32'h3100, 2'd0, 32'h0);
    set_fet(1'b1, 32'h600);
    push_exp(O_DAT, 32'h0);
    push_exp(O_FET, 32'h1111_2222);
    tick();
    check("post_rst_tie_grant", 32'(grant), 32'(O_DAT));
    check("post_rst_tie_mem_rw", 32'(mem_rw), 32'd0);
    tick();
    drop_req(O_DAT);
    tick();
    serve_busy("post_rst_fet", O_FET, 2'd2, 32'h600, 2'd3, 32'h0, 32'h1111_2222, 0);

    repeat (3) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
